// File: rtl/wb_mem_rr_arbiter_pkg.sv
// Shared constants for the four-master Wishbone memory arbiter.
// Holds the bus widths, the master count and the arbiter state encodings.
package wb_mem_rr_arbiter_pkg;

    localparam int ARB_NUM_MASTERS = 4;
    localparam int WB_DATA_W       = 32;
    localparam int WB_ADDR_W       = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/wb_mem_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches upward from (last+1) with wrap,
// so the previous winner has the lowest priority on the next pick.
module rr_pick4
    import wb_mem_rr_arbiter_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic       valid_o,
    output logic [1:0] win_o
);

    logic [1:0] idx;

    // Scan farthest-first so the nearest requester after last_i overwrites.
    always_comb begin
        valid_o = 1'b0;
        win_o   = 2'd0;
        idx     = 2'd0;
        for (int i = ARB_NUM_MASTERS; i >= 1; i--) begin
            idx = last_i + 2'(i);
            if (req_i[idx]) begin
                valid_o = 1'b1;
                win_o   = idx;
            end
        end
    end

endmodule

// File: rtl/wb_mem_rr_arbiter.sv
// Four-master round-robin Wishbone arbiter in front of the shared BRAM slave.
// One bus cycle per grant, no preemption, watchdog abort of stalled owners.
module wb_mem_rr_arbiter
    import wb_mem_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   i_m_cyc,
    input  logic [3:0]   i_m_stb,
    input  logic [3:0]   i_m_we,
    input  logic [15:0]  i_m_sel,
    input  logic [127:0] i_m_adr,
    input  logic [127:0] i_m_dat,
    output logic [31:0]  o_m_dat,
    output logic [3:0]   o_m_ack,
    output logic [3:0]   o_m_err,
    output logic [3:0]   o_m_int,
    output logic         o_s_cyc,
    output logic         o_s_stb,
    output logic         o_s_we,
    output logic [3:0]   o_s_sel,
    output logic [31:0]  o_s_adr,
    output logic [31:0]  o_s_dat,
    input  logic [31:0]  i_s_dat,
    input  logic         i_s_ack,
    input  logic         i_s_int,
    output logic [3:0]   o_grant,
    output logic         o_timeout,
    output logic [1:0]   o_timeout_id
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    logic [1:0]      state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [3:0]      grant_q, grant_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [1:0]      tid_q, tid_d;

    logic            pick_valid;
    logic [1:0]      pick_win;

    logic            own_cyc, own_stb, own_we;
    logic [3:0]      own_sel;
    logic [31:0]     own_adr, own_dat;
    logic            in_grant, owned, stall, abort;

    rr_pick4 u_pick (
        .req_i   (i_m_cyc),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    // last_q doubles as the owner index whenever the bus is owned.
    assign own_cyc = i_m_cyc[last_q];
    assign own_stb = i_m_stb[last_q];
    assign own_we  = i_m_we[last_q];
    assign own_sel = i_m_sel[{last_q, 2'b00} +: 4];
    assign own_adr = i_m_adr[{last_q, 5'b00000} +: WB_ADDR_W];
    assign own_dat = i_m_dat[{last_q, 5'b00000} +: WB_DATA_W];

    assign in_grant = (state_q == ST_GRANT);
    assign owned    = (state_q != ST_IDLE);
    assign stall    = in_grant && own_cyc && own_stb && !i_s_ack;
    // Abort fires in the stall cycle that would bring the count to TIMEOUT.
    assign abort    = (TIMEOUT > 0) && stall && (wd_q == WD_LAST);

    assign o_s_cyc = in_grant && own_cyc;
    assign o_s_stb = in_grant && own_cyc && own_stb;
    assign o_s_we  = in_grant && own_cyc && own_we;
    assign o_s_sel = owned ? own_sel : 4'd0;
    assign o_s_adr = owned ? own_adr : 32'd0;
    assign o_s_dat = owned ? own_dat : 32'd0;

    assign o_m_dat      = i_s_dat;
    assign o_m_int      = {ARB_NUM_MASTERS{i_s_int}};
    assign o_m_ack      = (in_grant && i_s_ack) ? grant_q : 4'd0;
    assign o_m_err      = abort ? grant_q : 4'd0;
    assign o_timeout    = abort;
    assign o_grant      = grant_q;
    assign o_timeout_id = tid_q;

    always_comb begin
        wd_d = '0;
        if ((TIMEOUT > 0) && stall && !abort) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        tid_d   = tid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    last_d  = pick_win;
                    grant_d = onehot4(pick_win);
                end
            end
            ST_GRANT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = 4'd0;
                end else if (abort) begin
                    state_d = ST_ABORT;
                    tid_d   = last_q;
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            grant_q <= 4'd0;
            wd_q    <= '0;
            tid_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
            tid_q   <= tid_d;
        end
    end

endmodule
